gated_reg_loader: RTL
=====================

# gated_reg_loader

Sequencer that drives the clock-gated 15-bit weight/activation register of the Binary-MLP datapath: it clears the register through its active-low section clears, then accepts a fixed number of words over a valid/ready handshake and, for each, presents the word on the register data bus while raising the clock-gate enable `l1` for exactly one cycle. It is the initiator side of the `din`/`l1`/`rst15`/`rst7` interface that the gated clock cell and gated register consume, and replaces hand-driven enable waveforms with a cycle-exact schedule.

## Interface
- `DW`, 15, data width of the gated register
- `NWORDS`, 8, words loaded per `start`, minimum 1
- `CLR_CYC`, 2, cycles the section clears are held low, minimum 1
- `GAP_CYC`, 1, idle cycles after each capture cycle, 0 allowed
- `clk`  in  1  single system clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load sequence; sampled only in IDLE
- `clr_lo_only`  in  1  sampled with `start`; 1 = clear only the 7-bit section (`rst7`), 0 = clear both sections
- `src_valid`  in  1  upstream word valid
- `src_ready`  out  1  loader accepts a word this cycle
- `src_data`  in  DW  upstream word
- `din`  out  DW  registered data to gated register
- `l1`  out  1  registered clock-gate enable to gated clock cell
- `rst15`  out  1  active-low clear, full-width section
- `rst7`  out  1  active-low clear, 7-bit section
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last capture

## Operation
- States: IDLE, CLEAR, LOAD, CAPT, GAP, DONE.
- IDLE: `start`=1 -> CLEAR, latch `clr_lo_only`, word count := 0, timer := CLR_CYC-1.
- CLEAR: `rst7`=0; `rst15`=0 unless latched `clr_lo_only`; `l1`=0. Stays CLR_CYC cycles, then LOAD.
- LOAD: `src_ready`=1. On `src_valid && src_ready`: `din` <= `src_data`, `l1` <= 1, count += 1, -> CAPT. No handshake: stay.
- CAPT: one cycle, `l1`=1, `src_ready`=0. Exit: count==NWORDS -> DONE; else GAP_CYC>0 -> GAP (timer := GAP_CYC-1); else LOAD.
- GAP: `l1`=0, `src_ready`=0 for GAP_CYC cycles, then LOAD.
- DONE: `done`=1 one cycle, -> IDLE.
- `din` holds its last value outside handshakes; never changes while `l1`=1.
- `start` outside IDLE ignored; `start` held high in IDLE after DONE re-triggers a new sequence.
- Count width $clog2(NWORDS+1); no wrap possible, count never exceeds NWORDS.

## Timing
- Reset values: `l1`=0, `rst15`=1, `rst7`=1, `din`=0, `src_ready`=0, `busy`=0, `done`=0, state IDLE.
- `rst` mid-sequence: next edge forces reset values regardless of state; partial load abandoned, no `done`.
- All outputs registered except `src_ready`, which is decoded from state (high iff LOAD).
- `start` at edge t -> clears low from edge t for CLR_CYC cycles -> `src_ready` high at edge t+CLR_CYC.
- Handshake at edge k -> `din` new and `l1`=1 during cycle (k, k+1]; downstream captures on gated edge k+1; `l1`=0 from edge k+1.
- Throughput: one word per 2+GAP_CYC cycles with `src_valid` held high.
- Last handshake at edge k -> `done`=1 during (k+1, k+2], `busy` low from k+2.
- `l1` and clears never active in the same cycle.

## Structure
- Package `gated_reg_pkg`: state enum typedef `gl_state_t`, default DW localparam.
- Sub-module `cyc_timer`: loadable down-counter with `load`, `value`, `zero` flag, shared by CLEAR and GAP.

## Test plan
- Reset/idle: `rst`=1 two cycles -> `l1`=0, `rst15`=`rst7`=1, `busy`=0; `start`=0 -> no activity for 20 cycles.
- Full load, NWORDS=4, CLR_CYC=2, GAP_CYC=1, `src_valid` held, data 15'h07FF, 15'h0FFE, 15'h1FFC, 15'h3FF8 -> clears low 2 cycles, four one-cycle `l1` pulses 3 cycles apart, `din` matches each word, gated register reads 15'h3FF8, `done` one pulse.
- `clr_lo_only`=1 with `start` -> only `rst7` low for 2 cycles, `rst15` stays 1.
- Backpressure: `src_valid` low 5 cycles in LOAD -> `src_ready` stays 1, `l1` stays 0, `din` unchanged; resumes correctly.
- GAP_CYC=0 -> `l1` pulses every 2nd cycle; `start` pulsed mid-load ignored.
- `rst` asserted in GAP after word 2 -> reset values next edge, no `done`; new `start` loads all NWORDS from count 0.

Source files
------------

// File: rtl/gated_reg_pkg.sv
// Shared types and constants for the gated register loader.
// Holds the sequencer state encoding and the default register width.
package gated_reg_pkg;

    localparam int unsigned DEF_DW = 15;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StCapt,
        StGap,
        StDone
    } gl_state_t;

    // Counter width that can hold v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter; o_zero flags that the loaded interval has elapsed.
// Shared by the clear-hold and inter-word gap intervals of the loader.
module cyc_timer #(
    parameter int unsigned W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gated_reg_loader.sv
// Sequencer for the clock-gated weight/activation register: section clears,
// then NWORDS handshaked words, each captured with a single-cycle l1 enable.
module gated_reg_loader
    import gated_reg_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned NWORDS  = 8,
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_clr_lo_only,
    input  logic          i_src_valid,
    output logic          o_src_ready,
    input  logic [DW-1:0] i_src_data,
    output logic [DW-1:0] o_din,
    output logic          o_l1,
    output logic          o_rst15,
    output logic          o_rst7,
    output logic          o_busy,
    output logic          o_done
);

    localparam int unsigned TMAX = (CLR_CYC > GAP_CYC) ? CLR_CYC : GAP_CYC;
    localparam int unsigned TW   = clog2_min1(TMAX + 1);
    localparam int unsigned CW   = clog2_min1(NWORDS + 1);

    localparam logic [TW-1:0] CLR_VAL = TW'(CLR_CYC - 1);
    localparam logic [TW-1:0] GAP_VAL = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;
    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS);

    gl_state_t      r_state;
    logic           r_lo_only;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_din;
    logic           r_l1;
    logic           r_rst15;
    logic           r_rst7;
    logic           r_busy;
    logic           r_done;

    logic           w_tmr_load;
    logic [TW-1:0]  w_tmr_value;
    logic           w_tmr_zero;
    logic           w_last;

    assign w_last = (r_cnt == LAST_CNT);

    // The timer is reloaded on the transitions into CLEAR and GAP only.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        if (r_state == StIdle && i_start) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = CLR_VAL;
        end else if (r_state == StCapt && !w_last) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = GAP_VAL;
        end
    end

    cyc_timer #(
        .W (TW)
    ) u_cyc_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_lo_only <= 1'b0;
            r_cnt     <= '0;
            r_din     <= '0;
            r_l1      <= 1'b0;
            r_rst15   <= 1'b1;
            r_rst7    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_l1   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state   <= StClear;
                        r_lo_only <= i_clr_lo_only;
                        r_cnt     <= '0;
                        r_rst7    <= 1'b0;
                        r_rst15   <= i_clr_lo_only;
                        r_busy    <= 1'b1;
                    end
                end
                StClear: begin
                    if (w_tmr_zero) begin
                        r_state <= StLoad;
                        r_rst7  <= 1'b1;
                        r_rst15 <= 1'b1;
                    end else begin
                        r_rst7  <= 1'b0;
                        r_rst15 <= r_lo_only;
                    end
                end
                StLoad: begin
                    if (i_src_valid) begin
                        r_din   <= i_src_data;
                        r_l1    <= 1'b1;
                        r_cnt   <= r_cnt + CW'(1);
                        r_state <= StCapt;
                    end
                end
                StCapt: begin
                    if (w_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else if (GAP_CYC > 0) begin
                        r_state <= StGap;
                    end else begin
                        r_state <= StLoad;
                    end
                end
                StGap: begin
                    if (w_tmr_zero) begin
                        r_state <= StLoad;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_src_ready = (r_state == StLoad);
    assign o_din       = r_din;
    assign o_l1        = r_l1;
    assign o_rst15     = r_rst15;
    assign o_rst7      = r_rst7;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
